// File: rtl/i_cache_fill_ctrl.sv
// i_cache_fill_ctrl: hit/LRU lookup and miss fill controller for a 2-way set-associative instruction cache
module i_cache_fill_ctrl #(
  parameter int TAG_W = 6,
  parameter int INDEX_W = 6,
  parameter int WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [15:0]               addr,
  input  logic [TAG_W+1:0]          tag_out_0,
  input  logic [TAG_W+1:0]          tag_out_1,
  input  logic [15:0]               mem_data,
  input  logic                      mem_valid,
  output logic                      hit,
  output logic                      hit_way,
  output logic                      stall,
  output logic [(1<<INDEX_W)-1:0]   block_en,
  output logic [WORDS-1:0]          word,
  output logic                      data_we_0,
  output logic                      data_we_1,
  output logic                      meta_we_0,
  output logic                      meta_we_1,
  output logic [15:0]               data_in,
  output logic [TAG_W+1:0]          tag_in_0,
  output logic [TAG_W+1:0]          tag_in_1,
  output logic                      mem_rd,
  output logic [15:0]               mem_addr
);
  localparam int CW = $clog2(WORDS);
  localparam int LO = CW + 1;
  localparam logic [1:0] IDLE = 2'd0, INVAL = 2'd1, FILL = 2'd2, COMMIT = 2'd3;
  logic [1:0] state;
  logic victim, issue_done, recv_done;
  logic [15:LO] miss_addr;
  logic [CW-1:0] issue_cnt, recv_cnt, word_sel;
  logic [INDEX_W-1:0] set_sel;
  logic [TAG_W-1:0] tag_0, tag_1, req_tag, miss_tag;
  logic v0, v1, mru0, mru1, m0, m1, idle, miss, pick, recv, inval, commit, upd, way_sel;
  logic [TAG_W+1:0] keep_0, keep_1, new_0, new_1;
  logic unused;
  assign unused = addr[0];
  assign {v0, mru0, tag_0} = tag_out_0;
  assign {v1, mru1, tag_1} = tag_out_1;
  assign req_tag = addr[15 -: TAG_W];
  assign miss_tag = miss_addr[15 -: TAG_W];
  assign idle = state == IDLE && !rst;
  assign m0 = v0 && tag_0 == req_tag;
  assign m1 = v1 && tag_1 == req_tag;
  assign hit = idle && req && (m0 || m1);
  assign hit_way = hit && !m0;
  assign miss = idle && req && !(m0 || m1);
  assign stall = !rst && (state != IDLE || miss);
  // first invalid way, else the non-MRU way, else way 0
  assign pick = v0 && (!v1 || (mru0 && !mru1));
  assign inval = state == INVAL && !rst;
  assign commit = state == COMMIT && !rst;
  assign recv = state == FILL && mem_valid && !recv_done && !rst;
  assign mem_rd = state == FILL && !issue_done && !rst;
  assign mem_addr = mem_rd ? {miss_addr, issue_cnt, 1'b0} : '0;
  assign set_sel = state == IDLE ? addr[LO +: INDEX_W] : miss_addr[LO +: INDEX_W];
  assign word_sel = state == IDLE ? addr[1 +: CW] : recv_cnt;
  assign block_en = rst ? '0 : {{((1<<INDEX_W)-1){1'b0}}, 1'b1} << set_sel;
  assign word = rst ? '0 : {{(WORDS-1){1'b0}}, 1'b1} << word_sel;
  assign data_in = mem_data;
  assign data_we_0 = recv && !victim;
  assign data_we_1 = recv && victim;
  assign meta_we_0 = hit || commit || (inval && !victim);
  assign meta_we_1 = hit || commit || (inval && victim);
  assign upd = hit || commit;
  assign way_sel = hit ? hit_way : victim;
  assign keep_0 = {v0, 1'b0, tag_0};
  assign keep_1 = {v1, 1'b0, tag_1};
  assign new_0 = {2'b11, hit ? tag_0 : miss_tag};
  assign new_1 = {2'b11, hit ? tag_1 : miss_tag};
  assign tag_in_0 = upd ? (way_sel ? keep_0 : new_0) : '0;
  assign tag_in_1 = upd ? (way_sel ? new_1 : keep_1) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      victim <= 1'b0;
      miss_addr <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
      issue_done <= 1'b0;
      recv_done <= 1'b0;
    end else begin
      if (miss) begin
        state <= INVAL;
        miss_addr <= addr[15:LO];
        victim <= pick;
        issue_cnt <= '0;
        recv_cnt <= '0;
        issue_done <= 1'b0;
        recv_done <= 1'b0;
      end
      if (state == INVAL) state <= FILL;
      if (mem_rd) begin
        issue_cnt <= issue_cnt + CW'(!(&issue_cnt));
        issue_done <= &issue_cnt;
      end
      if (recv) begin
        recv_cnt <= recv_cnt + CW'(!(&recv_cnt));
        recv_done <= &recv_cnt;
        if (&recv_cnt) state <= COMMIT;
      end
      if (state == COMMIT) state <= IDLE;
    end
  end
endmodule
